// File: rtl/text_console.sv
// text_console: CPU-side character terminal. Bytes written to the DATA register
// are queued in a small FIFO and drained by an FSM that prints them, handles
// CR/LF/BS/FF, keeps the cursor and drives the character RAM write port.
// Optional build macro: TEXT_CONSOLE_LINE_CLEAR_EN -- when defined, every row
// advance (LF or column wrap) blanks the new row before more bytes are drained.
module text_console #(
  parameter int FIFO_DEPTH = 16,
  parameter int COLS       = 40,
  parameter int ROWS       = 30
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  wren,
  input  logic [23:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ram_wr,
  output logic [10:0] ram_waddr,
  output logic [7:0]  ram_wdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [5:0]    COL_MAX   = 6'(COLS - 1);
  localparam logic [4:0]    ROW_MAX   = 5'(ROWS - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [7:0]    SPACE     = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DECODE     = 3'd1,
    S_PUT        = 3'd2,
    S_CLR_SCREEN = 3'd3
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
    , S_CLR_LINE = 3'd4
`endif
  } state_t;

`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
  localparam state_t S_ADV     = S_CLR_LINE;
  localparam logic   ADV_CLEAR = 1'b1;
`else
  localparam state_t S_ADV     = S_IDLE;
  localparam logic   ADV_CLEAR = 1'b0;
`endif

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          fifo_empty, fifo_full, push_req, push_ok, pop;
  logic          ctrl_wr, busy, overflow;
  logic [5:0]    col, col_next, clr_col, clr_col_next, set_col;
  logic [4:0]    row, row_next, clr_row, clr_row_next, set_row, row_adv;
  logic [7:0]    chr, chr_next;
  logic          put_noadv, put_noadv_next, put_wrap;
  logic          is_print, clr_line_last, clr_scr_last;
  logic          wr_next;
  logic [10:0]   waddr_next;
  logic [7:0]    wdata_next;
  logic          unused;

  assign push_req   = sel & ~address[2] & wren[0];
  assign ctrl_wr    = sel & address[2] & (|wren);
  assign fifo_empty = (count == {(AW + 1){1'b0}});
  assign fifo_full  = (count == FIFO_FULL);
  // A full FIFO still accepts a byte when one leaves in the same cycle.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign busy       = ~fifo_empty | (state != S_IDLE);
  assign data_out   = {overflow, busy, fifo_full, 16'h0000, row, 2'b00, col};

  assign set_col  = (data_in[5:0] > COL_MAX) ? COL_MAX : data_in[5:0];
  assign set_row  = (data_in[12:8] > ROW_MAX) ? ROW_MAX : data_in[12:8];
  assign row_adv  = (row == ROW_MAX) ? 5'd0 : row + 5'd1;
  assign is_print = ((chr >= 8'h20) && (chr <= 8'h7E)) || chr[7];
  assign put_wrap = ~put_noadv && (col == COL_MAX);
  assign clr_line_last = (clr_col == COL_MAX);
  assign clr_scr_last  = clr_line_last && (clr_row == ROW_MAX);

  assign unused = ^{address[23:3], address[1:0], data_in[30:13]};

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      wptr     <= {AW{1'b0}};
      rptr     <= {AW{1'b0}};
      count    <= {(AW + 1){1'b0}};
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop)     rptr <= rptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (ctrl_wr && data_in[31])
        overflow <= 1'b0;
      else if (push_req && !push_ok)
        overflow <= 1'b1;
    end
  end

  // FIFO storage; no reset needed because occupancy gates every read.
  always_ff @(posedge clk_cpu) begin
    if (push_ok) mem[wptr] <= data_in[7:0];
  end

  // FSM state register.
  always_ff @(posedge clk_cpu) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) state_next = S_DECODE;
        else             state_next = S_IDLE;
      end
      S_DECODE: begin
        if (is_print)                          state_next = S_PUT;
        else if (chr == 8'h0A)                 state_next = S_ADV;
        else if (chr == 8'h08 && col != 6'd0)  state_next = S_PUT;
        else if (chr == 8'h0C)                 state_next = S_CLR_SCREEN;
        else                                   state_next = S_IDLE;
      end
      S_PUT: begin
        if (put_wrap)         state_next = S_ADV;
        else if (!fifo_empty) state_next = S_DECODE;
        else                  state_next = S_IDLE;
      end
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
      S_CLR_LINE: begin
        if (clr_line_last) state_next = S_IDLE;
        else               state_next = S_CLR_LINE;
      end
`endif
      S_CLR_SCREEN: begin
        if (clr_scr_last) state_next = S_IDLE;
        else              state_next = S_CLR_SCREEN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: pops, cursor/counter updates and the next RAM write, which is
  // registered so the write port is driven straight from flops.
  always_comb begin
    pop            = 1'b0;
    col_next       = col;
    row_next       = row;
    chr_next       = chr;
    put_noadv_next = put_noadv;
    clr_col_next   = clr_col;
    clr_row_next   = clr_row;
    wr_next        = 1'b0;
    waddr_next     = ram_waddr;
    wdata_next     = ram_wdata;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          chr_next = mem[rptr];
        end else if (ctrl_wr && !data_in[31]) begin
          // Idle with an empty FIFO is exactly the not-busy condition.
          col_next = set_col;
          row_next = set_row;
        end else begin
          pop = 1'b0;
        end
      end
      S_DECODE: begin
        if (is_print) begin
          wr_next        = 1'b1;
          waddr_next     = {row, col};
          wdata_next     = chr;
          put_noadv_next = 1'b0;
        end else if (chr == 8'h0A) begin
          col_next = 6'd0;
          row_next = row_adv;
          if (ADV_CLEAR) begin
            wr_next      = 1'b1;
            waddr_next   = {row_adv, 6'd0};
            wdata_next   = SPACE;
            clr_col_next = 6'd0;
          end else begin
            wr_next = 1'b0;
          end
        end else if (chr == 8'h0D) begin
          col_next = 6'd0;
        end else if (chr == 8'h08 && col != 6'd0) begin
          // Backspace: blank the previous cell; PUT must not advance afterwards.
          col_next       = col - 6'd1;
          wr_next        = 1'b1;
          waddr_next     = {row, col - 6'd1};
          wdata_next     = SPACE;
          put_noadv_next = 1'b1;
        end else if (chr == 8'h0C) begin
          clr_col_next = 6'd0;
          clr_row_next = 5'd0;
          wr_next      = 1'b1;
          waddr_next   = 11'd0;
          wdata_next   = SPACE;
        end else begin
          wr_next = 1'b0;
        end
      end
      S_PUT: begin
        if (put_wrap) begin
          col_next = 6'd0;
          row_next = row_adv;
          if (ADV_CLEAR) begin
            wr_next      = 1'b1;
            waddr_next   = {row_adv, 6'd0};
            wdata_next   = SPACE;
            clr_col_next = 6'd0;
          end else begin
            wr_next = 1'b0;
          end
        end else begin
          if (!put_noadv) col_next = col + 6'd1;
          else            col_next = col;
          // Chain straight into the next byte, skipping IDLE.
          if (!fifo_empty) begin
            pop      = 1'b1;
            chr_next = mem[rptr];
          end else begin
            pop = 1'b0;
          end
        end
      end
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
      S_CLR_LINE: begin
        if (!clr_line_last) begin
          clr_col_next = clr_col + 6'd1;
          wr_next      = 1'b1;
          waddr_next   = {row, clr_col + 6'd1};
          wdata_next   = SPACE;
        end else begin
          wr_next = 1'b0;
        end
      end
`endif
      S_CLR_SCREEN: begin
        if (clr_scr_last) begin
          col_next = 6'd0;
          row_next = 5'd0;
        end else if (clr_line_last) begin
          clr_col_next = 6'd0;
          clr_row_next = clr_row + 5'd1;
          wr_next      = 1'b1;
          waddr_next   = {clr_row + 5'd1, 6'd0};
          wdata_next   = SPACE;
        end else begin
          clr_col_next = clr_col + 6'd1;
          wr_next      = 1'b1;
          waddr_next   = {clr_row, clr_col + 6'd1};
          wdata_next   = SPACE;
        end
      end
      default: begin
        wr_next = 1'b0;
      end
    endcase
  end

  // Cursor, decode byte, clear counters and registered RAM write port.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      col       <= 6'd0;
      row       <= 5'd0;
      chr       <= 8'h00;
      put_noadv <= 1'b0;
      clr_col   <= 6'd0;
      clr_row   <= 5'd0;
      ram_wr    <= 1'b0;
      ram_waddr <= 11'd0;
      ram_wdata <= 8'h00;
    end else begin
      col       <= col_next;
      row       <= row_next;
      chr       <= chr_next;
      put_noadv <= put_noadv_next;
      clr_col   <= clr_col_next;
      clr_row   <= clr_row_next;
      ram_wr    <= wr_next;
      ram_waddr <= waddr_next;
      ram_wdata <= wdata_next;
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: table of single-byte vectors plus hand-written
// sequences; every RAM write is compared against a queue of expected writes.
module tb_text_console;

  logic        clk_cpu;
  logic        reset;
  logic        sel;
  logic [3:0]  wren;
  logic [23:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ram_wr;
  logic [10:0] ram_waddr;
  logic [7:0]  ram_wdata;

  text_console dut (
    .clk_cpu  (clk_cpu),
    .reset    (reset),
    .sel      (sel),
    .wren     (wren),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .ram_wr   (ram_wr),
    .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  logic [18:0] sb [$];
  int wr_cyc [$];

  typedef struct {
    logic [5:0] set_col;
    logic [4:0] set_row;
    logic [7:0] ch;
    logic       exp_wr;
    logic [4:0] wr_row;
    logic [5:0] wr_col;
    logic [7:0] wr_data;
    logic [5:0] exp_col;
    logic [4:0] exp_row;
    logic       line_clr;
  } vec_t;

  vec_t vecs [12];

  always @(posedge clk_cpu) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: every RAM write must match the oldest expected entry.
  always @(negedge clk_cpu) begin
    if (ram_wr === 1'b1) begin
      wr_count = wr_count + 1;
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%03h data 0x%02h, expected no write",
                 ram_waddr, ram_wdata);
      end else begin
        logic [18:0] e;
        e = sb.pop_front();
        check("ram_write", {13'd0, ram_waddr, ram_wdata}, {13'd0, e});
      end
    end
  end

  task automatic exp_write(input logic [4:0] r, input logic [5:0] c, input logic [7:0] d);
    sb.push_back({r, c, d});
  endtask

  task automatic exp_line(input logic [4:0] r);
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
    for (int c = 0; c < 40; c++) exp_write(r, 6'(c), 8'h20);
`else
    r = r;
`endif
  endtask

  task automatic exp_screen();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++) exp_write(5'(r), 6'(c), 8'h20);
  endtask

  task automatic drive(input logic is_ctrl, input logic [31:0] d);
    @(negedge clk_cpu);
    sel     = 1'b1;
    address = is_ctrl ? 24'h000004 : 24'h000000;
    wren    = is_ctrl ? 4'b1000 : 4'b0001;
    data_in = d;
  endtask

  task automatic bus_idle();
    @(negedge clk_cpu);
    sel     = 1'b0;
    wren    = 4'b0000;
    address = 24'h000000;
    data_in = 32'h0000_0000;
  endtask

  task automatic cpu_write(input logic is_ctrl, input logic [31:0] d);
    drive(is_ctrl, d);
    bus_idle();
  endtask

  task automatic set_cursor(input logic [5:0] c, input logic [4:0] r);
    cpu_write(1'b1, {19'd0, r, 2'b00, c});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (data_out[30] === 1'b1 && n < 4000) begin
      @(negedge clk_cpu);
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL %s: busy=1 after %0d cycles, expected busy=0", name, n);
    end
  endtask

  initial begin
    int n, run, base, gap1, gap2;
    sel = 1'b0; wren = 4'b0000; address = 24'h000000; data_in = 32'h0000_0000;
    reset = 1'b1;

    vecs[0]  = '{6'd0,  5'd0,  8'h41, 1'b1, 5'd0,  6'd0,  8'h41, 6'd1,  5'd0,  1'b0};
    vecs[1]  = '{6'd39, 5'd2,  8'h42, 1'b1, 5'd2,  6'd39, 8'h42, 6'd0,  5'd3,  1'b1};
    vecs[2]  = '{6'd5,  5'd29, 8'h0A, 1'b0, 5'd0,  6'd0,  8'h00, 6'd0,  5'd0,  1'b1};
    vecs[3]  = '{6'd0,  5'd4,  8'h08, 1'b0, 5'd0,  6'd0,  8'h00, 6'd0,  5'd4,  1'b0};
    vecs[4]  = '{6'd7,  5'd6,  8'h07, 1'b0, 5'd0,  6'd0,  8'h00, 6'd7,  5'd6,  1'b0};
    vecs[5]  = '{6'd10, 5'd8,  8'h08, 1'b1, 5'd8,  6'd9,  8'h20, 6'd9,  5'd8,  1'b0};
    vecs[6]  = '{6'd12, 5'd9,  8'h0D, 1'b0, 5'd0,  6'd0,  8'h00, 6'd0,  5'd9,  1'b0};
    vecs[7]  = '{6'd3,  5'd1,  8'hFF, 1'b1, 5'd1,  6'd3,  8'hFF, 6'd4,  5'd1,  1'b0};
    vecs[8]  = '{6'd63, 5'd31, 8'h7E, 1'b1, 5'd29, 6'd39, 8'h7E, 6'd0,  5'd0,  1'b1};
    vecs[9]  = '{6'd0,  5'd0,  8'h7F, 1'b0, 5'd0,  6'd0,  8'h00, 6'd0,  5'd0,  1'b0};
    vecs[10] = '{6'd20, 5'd15, 8'h20, 1'b1, 5'd15, 6'd20, 8'h20, 6'd21, 5'd15, 1'b0};
    vecs[11] = '{6'd1,  5'd2,  8'h1F, 1'b0, 5'd0,  6'd0,  8'h00, 6'd1,  5'd2,  1'b0};

    // Reset state
    repeat (3) @(negedge clk_cpu);
    reset = 1'b0;
    @(negedge clk_cpu);
    check("reset_status", data_out, 32'h0000_0000);
    check("reset_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("reset_waddr", {21'd0, ram_waddr}, 32'd0);
    check("reset_wdata", {24'd0, ram_wdata}, 32'd0);

    // Table of single-byte vectors
    for (int i = 0; i < 12; i++) begin
      wait_idle("vec_idle");
      set_cursor(vecs[i].set_col, vecs[i].set_row);
      if (vecs[i].exp_wr) exp_write(vecs[i].wr_row, vecs[i].wr_col, vecs[i].wr_data);
      if (vecs[i].line_clr) exp_line(vecs[i].exp_row);
      cpu_write(1'b0, {24'h5A5A5A, vecs[i].ch});
      wait_idle("vec_drain");
      check($sformatf("vec%0d_status", i), data_out,
            {19'd0, vecs[i].exp_row, 2'b00, vecs[i].exp_col});
    end

    // Latency: push at edge N, write during cycle after N+2, col moves at N+3
    set_cursor(6'd30, 5'd20);
    exp_write(5'd20, 6'd30, 8'h4C);
    cpu_write(1'b0, 32'h0000_004C);
    @(negedge clk_cpu);
    check("lat_n1_wr", {31'd0, ram_wr}, 32'd0);
    @(negedge clk_cpu);
    check("lat_n2_wr", {31'd0, ram_wr}, 32'd1);
    check("lat_n2_col", {26'd0, data_out[5:0]}, 32'd30);
    @(negedge clk_cpu);
    check("lat_n3_wr", {31'd0, ram_wr}, 32'd0);
    check("lat_n3_col", {26'd0, data_out[5:0]}, 32'd31);
    wait_idle("lat_drain");

    // Throughput: back-to-back printable bytes are written every 2 cycles
    set_cursor(6'd0, 5'd10);
    for (int i = 0; i < 3; i++) exp_write(5'd10, 6'(i), 8'(8'h61 + i));
    wr_cyc.delete();
    for (int i = 0; i < 3; i++) drive(1'b0, {24'd0, 8'(8'h61 + i)});
    bus_idle();
    wait_idle("thr_drain");
    check("thr_writes", wr_cyc.size(), 3);
    gap1 = (wr_cyc.size() >= 2) ? wr_cyc[1] - wr_cyc[0] : -1;
    gap2 = (wr_cyc.size() >= 3) ? wr_cyc[2] - wr_cyc[1] : -1;
    check("thr_gap1", gap1, 2);
    check("thr_gap2", gap2, 2);
    check("thr_status", data_out, {19'd0, 5'd10, 2'b00, 6'd3});

    // Screen clear: 1200 consecutive writes, cursor home, idle right after
    set_cursor(6'd10, 5'd10);
    exp_screen();
    cpu_write(1'b0, 32'h0000_000C);
    n = 0;
    while (ram_wr !== 1'b1 && n < 20) begin @(negedge clk_cpu); n++; end
    run = 0;
    while (ram_wr === 1'b1 && run < 1300) begin @(negedge clk_cpu); run++; end
    check("clr_run_length", run, 1200);
    check("clr_done_status", data_out, 32'h0000_0000);

    // Overflow: 20 bytes during a screen clear, 16 kept and 4 dropped
    wait_idle("ovf_idle");
    exp_screen();
    for (int i = 0; i < 16; i++) exp_write(5'd0, 6'(i), 8'(8'h41 + i));
    drive(1'b0, 32'h0000_000C);
    for (int i = 0; i < 20; i++) drive(1'b0, {24'hA5A5A5, 8'(8'h41 + i)});
    bus_idle();
    check("ovf_flags", {29'd0, data_out[31:29]}, 32'd7);
    wait_idle("ovf_drain");
    check("ovf_status", data_out, 32'h8000_0010);
    cpu_write(1'b1, 32'h8000_0000);
    check("ovf_cleared", data_out, 32'h0000_0010);
    check("sb_empty", sb.size(), 0);

    // Reset in the middle of a screen clear with bytes queued
    exp_screen();
    base = wr_count;
    cpu_write(1'b0, 32'h0000_000C);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0000_005A);
    bus_idle();
    n = 0;
    while ((wr_count - base) < 100 && n < 2000) begin
      @(negedge clk_cpu);
      #1;
      n++;
    end
    check("rst_writes_before", wr_count - base, 100);
    reset = 1'b1;
    @(negedge clk_cpu);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_status", data_out, 32'h0000_0000);
    @(negedge clk_cpu);
    reset = 1'b0;
    sb.delete();
    repeat (30) @(negedge clk_cpu);
    check("rst_no_more_writes", wr_count - base, 100);
    check("rst_status_after", data_out, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
